// File: rtl/fpram_wr_arb.sv
// CRAM/SFILE write-port arbiter: DMA first, Z80 writes queued and drained when idle. Issue is registered (N+1).
// DMA sees dma_stall only in the one-cycle FORCE slot. FPRAM_WR_COALESCE_EN merges a Z80 write into a matching tail entry.
module fpram_wr_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        z_we,
  input  logic        z_sel,
  input  logic [7:0]  z_addr,
  input  logic [15:0] z_data,
  input  logic        dma_cram_we,
  input  logic        dma_sfile_we,
  input  logic [7:0]  dma_addr,
  input  logic [15:0] dma_data,
  output logic        dma_stall,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cram_we,
  output logic        sfile_we,
  output logic [4:0]  q_level,
  output logic        q_ovf,
  input  logic        q_ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_DMA, ST_DRAIN, ST_FORCE} state_t;

  typedef struct packed {
    logic        sel;
    logic [7:0]  addr;
    logic [15:0] data;
  } entry_t;

  state_t state, state_nxt;

  entry_t mem [DEPTH];
  entry_t head, z_ent, dma_ent, iss;

  logic [AW:0]   wptr, rptr, level;
  logic [AW-1:0] head_idx;
  logic [CW-1:0] starve, starve_nxt;

  logic empty, full, dma_act;
  logic iss_vld, dma_iss, pop, z_byp;
  logic z_pend, coal, push, drop;

  assign level    = wptr - rptr;
  assign empty    = (level == '0);
  assign full     = (level == FULL_LVL);
  assign head_idx = rptr[AW-1:0];
  assign head     = mem[head_idx];
  assign q_level  = 5'(level);

  assign z_ent   = '{sel: z_sel, addr: z_addr, data: z_data};
  // CRAM wins when DMA raises both strobes.
  assign dma_ent = '{sel: ~dma_cram_we, addr: dma_addr, data: dma_data};
  assign dma_act = (dma_cram_we | dma_sfile_we) & ~dma_stall;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dma_stall <= 1'b0;
    end else begin
      state     <= state_nxt;
      dma_stall <= (state_nxt == ST_FORCE);
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = ST_IDLE;
    if (state != ST_FORCE && starve_nxt == CNT_MAX)
      state_nxt = ST_FORCE;
    else if (dma_iss)
      state_nxt = ST_DMA;
    else if (pop)
      state_nxt = ST_DRAIN;
  end

  // ------------------------------------------------------------------
  // FSM: outputs (issue selection for this cycle)
  // ------------------------------------------------------------------
  always_comb begin
    iss_vld = 1'b0;
    iss     = '0;
    dma_iss = 1'b0;
    pop     = 1'b0;
    z_byp   = 1'b0;
    if (state == ST_FORCE && !empty) begin
      iss_vld = 1'b1;
      iss     = head;
      pop     = 1'b1;
    end else if (dma_act) begin
      iss_vld = 1'b1;
      iss     = dma_ent;
      dma_iss = 1'b1;
    end else if (!empty) begin
      iss_vld = 1'b1;
      iss     = head;
      pop     = 1'b1;
    end else if (z_we) begin
      iss_vld = 1'b1;
      iss     = z_ent;
      z_byp   = 1'b1;
    end
  end

  assign z_pend = z_we & ~z_byp;

`ifdef FPRAM_WR_COALESCE_EN
  logic [AW-1:0] tail_idx;
  assign tail_idx = wptr[AW-1:0] - AW'(1);
  // A tail that is leaving this cycle cannot absorb the write.
  assign coal = z_pend & ~empty
              & (mem[tail_idx].sel == z_sel) & (mem[tail_idx].addr == z_addr)
              & ~(pop & (level == (AW+1)'(1)));
`else
  assign coal = 1'b0;
`endif

  assign push = z_pend & ~coal & ~full;
  assign drop = z_pend & ~coal & full;

  // ------------------------------------------------------------------
  // Z80 write queue
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= z_ent;
`ifdef FPRAM_WR_COALESCE_EN
    if (coal)
      mem[tail_idx].data <= z_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)
        wptr <= wptr + (AW+1)'(1);
      if (pop)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  // ------------------------------------------------------------------
  // Starvation guard
  // ------------------------------------------------------------------
  always_comb begin
    starve_nxt = starve;
    if (empty || pop)
      starve_nxt = '0;
    else if (dma_iss && starve != CNT_MAX)
      starve_nxt = starve + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve <= '0;
    else
      starve <= starve_nxt;
  end

  // ------------------------------------------------------------------
  // Registered write port and overflow flag
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cram_we  <= 1'b0;
      sfile_we <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      cram_we  <= iss_vld & ~iss.sel;
      sfile_we <= iss_vld & iss.sel;
      if (iss_vld) begin
        wr_addr <= iss.addr;
        wr_data <= iss.data;
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q_ovf <= 1'b0;
    else if (drop)
      q_ovf <= 1'b1;
    else if (q_ovf_clr)
      q_ovf <= 1'b0;
  end

  a_we_excl: assert property (@(posedge clk) disable iff (!rst_n) !(cram_we && sfile_we));
  a_force_nonempty: assert property (@(posedge clk) disable iff (!rst_n) (state == ST_FORCE) |-> !empty);

endmodule

// File: doc/fpram_wr_arb.md
Name: fpram_wr_arb

Overview:
- Arbitrates the shared FPGA-RAM write port (CRAM and SFILE) between Z80 memory-mapped word writes and the DMA engine.
- DMA has priority, but Z80 writes are never silently lost. They are queued in a small FIFO and drained in idle cycles.
- A starvation guard forces a Z80 slot during long DMA bursts.
- Sits between the Z80 file-map decoder / DMA engine and the CRAM/SFILE write ports.

Parameters:
- DEPTH, 4, Z80 write-queue entries; power of 2, range 2..16.
- STARVE_MAX, 16, consecutive DMA-issued cycles with a non-empty queue before a forced Z80 slot; ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- z_we  in  1  Z80 assembled-word write strobe, 1-cycle pulse
- z_sel  in  1  Z80 target: 0=CRAM, 1=SFILE
- z_addr  in  8  Z80 word address
- z_data  in  16  Z80 word data
- dma_cram_we  in  1  DMA CRAM write strobe
- dma_sfile_we  in  1  DMA SFILE write strobe
- dma_addr  in  8  DMA word address
- dma_data  in  16  DMA word data
- dma_stall  out  1  DMA strobes this cycle are not accepted; the source must re-present them
- wr_addr  out  8  port address
- wr_data  out  16  port data
- cram_we  out  1  CRAM write enable
- sfile_we  out  1  SFILE write enable
- q_level  out  5  queue occupancy, 0..DEPTH
- q_ovf  out  1  sticky overflow flag
- q_ovf_clr  in  1  clears q_ovf

Behaviour:
- Reset: all outputs 0, queue empty, state IDLE, starve counter 0.
- All port outputs are registered. A write accepted in cycle N drives cram_we/sfile_we/wr_addr/wr_data in cycle N+1, for exactly one cycle.
- cram_we and sfile_we are never both 1.
- dma_act = (dma_cram_we | dma_sfile_we) & ~dma_stall.
- If DMA asserts both strobes, CRAM wins and the SFILE strobe is ignored.
- Issue priority, evaluated each cycle:
  1. FORCE state: queue head.
  2. dma_act: DMA write.
  3. Queue non-empty: queue head.
  4. z_we with queue empty: Z80 bypass, no enqueue.
- z_we that is not issued in its own cycle is enqueued at the tail (sel, addr, data) if not full.
- Enqueue and pop in the same cycle are both allowed; level is unchanged.
- Full and z_we not issued: write dropped, q_ovf←1.
- q_ovf_clr clears q_ovf; a drop in the same cycle wins, so q_ovf stays 1.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. q_level = wptr−rptr.
- States:
  - IDLE: queue empty, no DMA.
  - DMA: DMA issued this cycle.
  - DRAIN: queue head issued.
  - FORCE: one cycle; dma_stall=1, queue head issued.
  - Next state is recomputed each cycle from the priority rules. FORCE always exits after one cycle.
- Starve counter:
  - +1 on each cycle a DMA write is issued while the queue is non-empty.
  - Cleared on any pop, or when the queue is empty.
  - When the counter reaches STARVE_MAX, the next cycle is FORCE; dma_stall is registered and high during FORCE.
  - The counter saturates at STARVE_MAX.
- During FORCE, the z_we enqueue/bypass rules still apply. Bypass is impossible because the head is issued.
- Reset mid-burst: queue contents are discarded and no write is emitted after rst_n deasserts until new stimulus arrives.

Optional Feature:
- Macro FPRAM_WR_COALESCE_EN.
- With it: a z_we that would be enqueued, whose sel and addr equal the current tail entry, overwrites the tail data instead of allocating. Level is unchanged and no overflow occurs even when full.
- The tail is not eligible when it is being popped that same cycle; that case takes the normal enqueue path.
- Without it: every queued z_we allocates a new entry.

Test Plan:
- Idle bypass: z_we, sel=0, addr=0x12, data=0xABCD at cycle N -> cram_we=1, wr_addr=0x12, wr_data=0xABCD at N+1 only; q_level stays 0.
- Collision: dma_sfile_we (addr 0x40, data 0x1111) and z_we (CRAM 0x05, 0x2222) in the same cycle N -> sfile_we at N+1; q_level=1 at N+1; cram_we 0x05/0x2222 at N+2; q_level=0.
- Overflow: DEPTH=4, continuous DMA for 5 z_we -> q_level=4 and q_ovf=1. The 5th write never appears. q_ovf_clr clears q_ovf the next cycle.
- Starvation: 1 queued write plus DMA strobes held high -> 16 DMA writes issued, then 1 cycle with dma_stall=1 emitting the queued write, then DMA resumes.
- Async reset: assert rst_n=0 with q_level=3 -> all outputs 0 immediately; after release no cram_we/sfile_we pulses.
- Coalesce (macro on): under DMA, two z_we to SFILE 0x33 with data 0x0001 then 0x0002 -> q_level=1; after DMA stops, a single sfile_we with 0x0002. With the macro off: two writes, 0x0001 then 0x0002.
